// File: rtl/instruction_decode_queue.sv
// Instruction queue with head decoder and registered output stage.
// Includes flush and a one-bubble load-use interlock with a saturating bubble counter.
module instruction_decode_queue #(
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 16,
   parameter bit HAZARD_CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:31]      instruction,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:4]       rA_address,
   output logic [0:4]       rB_address,
   output logic [0:4]       rD_address,
   output logic [0:5]       alu_operation,
   output logic [0:15]      immediate_address,
   output logic [0:2]       ppp,
   output logic [0:1]       ww,
   output logic             alu,
   output logic             sfu,
   output logic             ld,
   output logic             sd,
   output logic             bez,
   output logic             bnez,
   output logic             nop,
   output logic [0:CNT_W-1] hazard_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [0:5] OP_ALU  = 6'b101010;
   localparam logic [0:5] OP_LD   = 6'b100000;
   localparam logic [0:5] OP_SD   = 6'b100001;
   localparam logic [0:5] OP_BEZ  = 6'b100010;
   localparam logic [0:5] OP_BNEZ = 6'b100011;

   typedef struct packed {
      logic [0:4]  ra;
      logic [0:4]  rb;
      logic [0:4]  rd;
      logic [0:5]  aluop;
      logic [0:15] imm;
      logic [0:2]  ppp;
      logic [0:1]  ww;
      logic        alu;
      logic        sfu;
      logic        ld;
      logic        sd;
      logic        bez;
      logic        bnez;
      logic        nop;
   } dec_t;

   logic [0:31]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;
   dec_t               r_dec;
   logic               r_out_valid;
   logic [0:CNT_W-1]   r_hazard_count;

   logic [0:31]        w_head;
   logic [0:5]         w_funct;
   dec_t               w_dec;
   logic               w_not_empty;
   logic               w_src_hit;
   logic               w_hazard;
   logic               w_push;
   logic               w_pop;
   logic               w_bubble;

   assign w_head  = r_mem[r_rd_ptr];
   assign w_funct = w_head[26:31];

   always_comb begin
      w_dec = '0;
      case (w_head[0:5])
         OP_ALU: begin
            w_dec.rd    = w_head[6:10];
            w_dec.ra    = w_head[11:15];
            w_dec.ppp   = w_head[21:23];
            w_dec.ww    = w_head[24:25];
            w_dec.aluop = w_funct;
            // Single-source and special-function ops carry no rB operand.
            if (!(w_funct == 6'b000100 || w_funct == 6'b000101 ||
                  w_funct == 6'b001101 || w_funct[1]))
               w_dec.rb = w_head[16:20];
            if (w_funct[1]) w_dec.sfu = 1'b1;
            else            w_dec.alu = 1'b1;
         end
         OP_LD, OP_SD, OP_BEZ, OP_BNEZ: begin
            w_dec.rd   = w_head[6:10];
            w_dec.imm  = w_head[16:31];
            w_dec.ld   = (w_head[0:5] == OP_LD);
            w_dec.sd   = (w_head[0:5] == OP_SD);
            w_dec.bez  = (w_head[0:5] == OP_BEZ);
            w_dec.bnez = (w_head[0:5] == OP_BNEZ);
         end
         default: w_dec.nop = 1'b1;
      endcase
   end

   assign w_not_empty = (r_count != '0);
   assign in_ready    = (r_count < FULL_CNT);

   // rd=0 on the held load never matches, so a decoded rb of 0 cannot alias.
   assign w_src_hit = r_out_valid && r_dec.ld && (r_dec.rd != 5'd0) &&
                      (((w_dec.alu || w_dec.sfu) &&
                        (w_dec.ra == r_dec.rd || w_dec.rb == r_dec.rd)) ||
                       ((w_dec.sd || w_dec.bez || w_dec.bnez) && w_dec.rd == r_dec.rd));

   assign w_hazard = HAZARD_CHECK && w_not_empty && w_src_hit;
   assign w_push   = in_valid && in_ready && !flush;
   assign w_pop    = w_not_empty && (!r_out_valid || out_ready) && !w_hazard && !flush;
   assign w_bubble = w_hazard && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= instruction;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_dec          <= '0;
         r_out_valid    <= 1'b0;
         r_hazard_count <= '0;
      end else begin
         if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dec       <= '0;
            r_out_valid <= 1'b0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
            if (w_pop) begin
               r_dec       <= w_dec;
               r_out_valid <= 1'b1;
            end else if (out_ready) begin
               r_dec       <= '0;
               r_out_valid <= 1'b0;
            end
         end
         if (w_bubble && (r_hazard_count != '1))
            r_hazard_count <= r_hazard_count + 1'b1;
      end
   end

   assign out_valid         = r_out_valid;
   assign rA_address        = r_dec.ra;
   assign rB_address        = r_dec.rb;
   assign rD_address        = r_dec.rd;
   assign alu_operation     = r_dec.aluop;
   assign immediate_address = r_dec.imm;
   assign ppp               = r_dec.ppp;
   assign ww                = r_dec.ww;
   assign alu               = r_dec.alu;
   assign sfu               = r_dec.sfu;
   assign ld                = r_dec.ld;
   assign sd                = r_dec.sd;
   assign bez               = r_dec.bez;
   assign bnez              = r_dec.bnez;
   assign nop               = r_dec.nop;
   assign hazard_count      = r_hazard_count;

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Directed bench: two instances share stimulus, one with the load-use interlock disabled.
module tb_instruction_decode_queue;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [0:31] instruction;

   logic        in_ready, out_valid, alu, sfu, ld, sd, bez, bnez, nop;
   logic [0:4]  rA_address, rB_address, rD_address;
   logic [0:5]  alu_operation;
   logic [0:15] immediate_address, hazard_count;
   logic [0:2]  ppp;
   logic [0:1]  ww;

   logic        in_ready_b, out_valid_b, alu_b, sfu_b, ld_b, sd_b, bez_b, bnez_b, nop_b;
   logic [0:4]  rA_b, rB_b, rD_b;
   logic [0:5]  alu_operation_b;
   logic [0:15] imm_b, hazard_count_b;
   logic [0:2]  ppp_b;
   logic [0:1]  ww_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instruction_decode_queue #(.FIFO_DEPTH(4), .CNT_W(16), .HAZARD_CHECK(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
      .rA_address(rA_address), .rB_address(rB_address), .rD_address(rD_address),
      .alu_operation(alu_operation), .immediate_address(immediate_address),
      .ppp(ppp), .ww(ww), .alu(alu), .sfu(sfu), .ld(ld), .sd(sd), .bez(bez),
      .bnez(bnez), .nop(nop), .hazard_count(hazard_count)
   );

   instruction_decode_queue #(.FIFO_DEPTH(4), .CNT_W(16), .HAZARD_CHECK(1'b0)) dut_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .instruction(instruction), .out_valid(out_valid_b), .out_ready(out_ready),
      .rA_address(rA_b), .rB_address(rB_b), .rD_address(rD_b),
      .alu_operation(alu_operation_b), .immediate_address(imm_b),
      .ppp(ppp_b), .ww(ww_b), .alu(alu_b), .sfu(sfu_b), .ld(ld_b), .sd(sd_b), .bez(bez_b),
      .bnez(bnez_b), .nop(nop_b), .hazard_count(hazard_count_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_alu(input logic [4:0] rd, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [2:0] p,
                                          input logic [1:0] w, input logic [5:0] f);
      return {6'b101010, rd, ra, rb, p, w, f};
   endfunction

   // rA field is deliberately nonzero so the decoder must zero it.
   function automatic logic [31:0] mk_mem(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [15:0] imm);
      return {op, rd, 5'd9, imm};
   endfunction

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_hazard_count", hazard_count, 0);
      check("rst_alu", alu, 0);
      reset = 1'b0;

      // First instruction: visible after the second edge
      out_ready = 1'b1; in_valid = 1'b1; instruction = 32'hA8221000;
      tick(); in_valid = 1'b0;
      check("lat_edge1_valid", out_valid, 0);
      tick();
      check("a822_valid", out_valid, 1);
      check("a822_alu", alu, 1);
      check("a822_rd", rD_address, 1);
      check("a822_ra", rA_address, 2);
      check("a822_rb", rB_address, 2);
      check("a822_aluop", alu_operation, 0);
      tick();
      check("a822_drained", out_valid, 0);

      // rB suppression and sfu class, back to back
      in_valid = 1'b1;
      instruction = mk_alu(5'd4, 5'd5, 5'd7, 3'b101, 2'b10, 6'b000101);
      tick();
      instruction = mk_alu(5'd4, 5'd5, 5'd7, 3'b000, 2'b00, 6'b010000);
      tick(); in_valid = 1'b0;
      check("f05_rb", rB_address, 0);
      check("f05_alu", alu, 1);
      check("f05_aluop", alu_operation, 5);
      check("f05_ra", rA_address, 5);
      check("f05_ppp", ppp, 5);
      check("f05_ww", ww, 2);
      tick();
      check("f10_valid", out_valid, 1);
      check("f10_sfu", sfu, 1);
      check("f10_alu", alu, 0);
      check("f10_rb", rB_address, 0);
      check("f10_aluop", alu_operation, 16);
      tick();

      // Fill FIFO plus output register while stalled
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         instruction = mk_alu(5'(10 + i), 5'd0, 5'd0, 3'b000, 2'b00, 6'b000000);
         tick();
         if (i == 3) check("fill_in_ready_3", in_ready, 1);
      end
      in_valid = 1'b0;
      check("fill_in_ready_full", in_ready, 0);
      check("fill_hold_rd", rD_address, 10);
      tick();
      check("fill_hold_rd2", rD_address, 10);
      check("fill_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         check("drain_valid", out_valid, 1);
         check("drain_rd", rD_address, 64'(10 + i));
      end
      check("drain_in_ready", in_ready, 1);
      tick();
      check("drain_empty", out_valid, 0);

      // Load-use: LD r3 then ALU reading r3
      in_valid = 1'b1; instruction = mk_mem(6'b100000, 5'd3, 16'h1234);
      tick();
      instruction = mk_alu(5'd6, 5'd3, 5'd0, 3'b000, 2'b00, 6'b000000);
      tick(); in_valid = 1'b0;
      check("ld_flag", ld, 1);
      check("ld_rd", rD_address, 3);
      check("ld_ra", rA_address, 0);
      check("ld_imm", immediate_address, 16'h1234);
      tick();
      check("bubble_valid", out_valid, 0);
      check("bubble_count", hazard_count, 1);
      check("nochk_valid", out_valid_b, 1);
      check("nochk_rd", rD_b, 6);
      tick();
      check("after_bubble_alu", alu, 1);
      check("after_bubble_rd", rD_address, 6);
      check("after_bubble_ra", rA_address, 3);
      check("nochk_drained", out_valid_b, 0);
      check("nochk_count", hazard_count_b, 0);
      tick();

      // LD r3 then ALU with rA=0: no bubble
      in_valid = 1'b1; instruction = mk_mem(6'b100000, 5'd3, 16'h0001);
      tick();
      instruction = mk_alu(5'd7, 5'd0, 5'd0, 3'b000, 2'b00, 6'b000000);
      tick(); in_valid = 1'b0;
      tick();
      check("nohaz_valid", out_valid, 1);
      check("nohaz_rd", rD_address, 7);
      check("nohaz_count", hazard_count, 1);
      tick();

      // LD r3 then BEZ r3: bubble through the rD source
      in_valid = 1'b1; instruction = mk_mem(6'b100000, 5'd3, 16'h0002);
      tick();
      instruction = mk_mem(6'b100010, 5'd3, 16'hBEEF);
      tick(); in_valid = 1'b0;
      tick();
      check("bez_bubble_valid", out_valid, 0);
      check("bez_bubble_count", hazard_count, 2);
      tick();
      check("bez_flag", bez, 1);
      check("bez_imm", immediate_address, 16'hBEEF);
      tick();

      // LD r0 then SD r0: register 0 never interlocks
      in_valid = 1'b1; instruction = mk_mem(6'b100000, 5'd0, 16'h0003);
      tick();
      instruction = mk_mem(6'b100001, 5'd0, 16'h0004);
      tick(); in_valid = 1'b0;
      tick();
      check("r0_sd_valid", out_valid, 1);
      check("r0_sd_flag", sd, 1);
      check("r0_count", hazard_count, 2);
      tick();

      // Unknown opcodes decode as nop with zero fields
      in_valid = 1'b1; instruction = 32'hF3FFFFFF;
      tick();
      instruction = 32'h03FFFFFF;
      tick(); in_valid = 1'b0;
      check("nop1_flag", nop, 1);
      check("nop1_rd", rD_address, 0);
      check("nop1_imm", immediate_address, 0);
      check("nop1_alu", alu, 0);
      tick();
      check("nop0_flag", nop, 1);
      check("nop0_ra", rA_address, 0);
      check("nop0_aluop", alu_operation, 0);
      tick();

      // Flush with 3 queued + 1 held and a push offered
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         instruction = mk_alu(5'(20 + i), 5'd0, 5'd0, 3'b000, 2'b00, 6'b000000);
         tick();
      end
      check("preflush_rd", rD_address, 20);
      instruction = mk_alu(5'd25, 5'd0, 5'd0, 3'b000, 2'b00, 6'b000000);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_rd", rD_address, 0);
      check("flush_alu", alu, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_count_kept", hazard_count, 2);
      out_ready = 1'b1;
      tick(); tick();
      check("flush_dropped", out_valid, 0);
      in_valid = 1'b1; instruction = mk_alu(5'd26, 5'd0, 5'd0, 3'b000, 2'b00, 6'b000000);
      tick(); in_valid = 1'b0;
      tick();
      check("postflush_rd", rD_address, 26);
      check("postflush_valid", out_valid, 1);
      tick();

      // Asynchronous reset between edges
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         instruction = mk_alu(5'(9 + i), 5'd1, 5'd0, 3'b000, 2'b00, 6'b000000);
         tick();
      end
      in_valid = 1'b0;
      check("prerst_in_ready", in_ready, 0);
      #3;
      reset = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_rd", rD_address, 0);
      check("arst_alu", alu, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_count", hazard_count, 0);
      #2;
      reset = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      check("arst_empty", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
